mips_cpu_run_monitor: RTL and testbench
=======================================

Name: mips_cpu_run_monitor

Overview:
Synthesizable run-controller and bus-protocol checker for the Harvard MIPS CPU.
- Sequences the CPU reset and arms a run on a start pulse.
- Watches the instruction and data buses every cycle and enforces a cycle timeout.
- When the CPU drops active, compares register_v0 against a reference value and reports pass or a fail code.
- Generalises the one-shot simulation bench into reusable RTL: configurable reset length, timeout, counter width and legal data-address window, plus access counters. Sits beside mips_cpu_harvard in simulation and FPGA test harnesses.

Parameters:
TIMEOUT_CYCLES, 1000, RUN cycles allowed before a timeout fail.
RST_CYCLES, 1, cycles cpu_rst is held high in the RESET state (at least 1).
CNT_W, 32, width of cycle_count, read_count and write_count.
ADDR_LO, 32'h0000_0000, lowest legal data_address (inclusive).
ADDR_HI, 32'hFFFF_FFFF, highest legal data_address (inclusive).
CHECK_ALIGN, 0, 1 makes any data access with data_address[1:0] != 0 an error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse that arms a run
cpu_active  input  1  CPU active flag
register_v0  input  32  CPU $v0 value
instr_address  input  32  CPU instruction address
data_address  input  32  CPU data address
data_read  input  1  CPU data read strobe
data_write  input  1  CPU data write strobe
ref_out  input  32  expected $v0; sampled in the CHECK state
cpu_rst  output  1  active-high reset driven to the CPU
done  output  1  run finished (pass or fail)
pass  output  1  run finished with fail_code==0
fail_code  output  3  0 none, 1 bus active in reset, 2 not active after reset, 3 read&write, 4 write to instr_address, 5 address out of window or misaligned, 6 timeout, 7 v0 mismatch
cycle_count  output  CNT_W  RUN cycles elapsed
read_count  output  CNT_W  data_read cycles in RUN
write_count  output  CNT_W  data_write cycles in RUN

Behaviour:
- Async reset (rst low) forces state IDLE.
  - cpu_rst=1; done, pass and fail_code are 0; all counters are 0.
- States and transitions:
  - IDLE: start goes to RESET, clearing counters and fail_code.
  - RESET: cpu_rst=1 for RST_CYCLES cycles. From the second RESET cycle onward, any data_read or data_write sets fail 1. Then goes to WAIT.
  - WAIT: one cycle, cpu_rst=0. cpu_active==0 sets fail 2; otherwise goes to RUN.
  - RUN: cpu_rst=0; per-cycle checks are listed below. cpu_active==0 goes to CHECK.
  - CHECK: register_v0 != ref_out sets fail 7; then goes to DONE.
  - DONE: done=1; pass=(fail_code==0); cpu_rst=1 halts the CPU. start re-arms to RESET, clearing counters, done and fail_code.
- Any fail goes to DONE on the next edge.
- Counters are frozen outside RUN.
- RUN checks on each rising edge:
  - cycle_count increments.
  - read_count increments if data_read; write_count increments if data_write.
  - Counters saturate at all-ones.
  - Fail 3: data_read && data_write.
  - Fail 4: data_write && data_address == instr_address.
  - Fail 5: a data access with data_address outside [ADDR_LO, ADDR_HI], or (CHECK_ALIGN && data_address[1:0] != 0).
  - Fail 6: cycle_count == TIMEOUT_CYCLES-1 while cpu_active is still 1.
- Simultaneous errors in one cycle: the lowest nonzero code is recorded.
- The first recorded fail is sticky until re-arm or reset.
- The active-drop check takes priority over timeout in the same cycle: cpu_active==0 goes to CHECK with no fail 6.
- start is ignored in RESET, WAIT, RUN and CHECK.
- rst asserted mid-run: immediate return to IDLE with cpu_rst=1 and no done pulse.
- All outputs are registered. done and pass rise one cycle after the deciding edge.

Optional Feature:
Macro: MIPS_RUN_MONITOR_FAIL_CAPTURE_EN.
- Defined: adds outputs fail_instr_address[31:0] and fail_data_address[31:0], latched on the edge that records the first fail. Both reset and re-arm to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- CPU model asserts active one cycle after reset release, runs 50 cycles, drops active with v0=ref_out=32'h0000_0007 → done=1, pass=1, fail_code=0, cycle_count=50.
- data_read and data_write both high in RUN cycle 10 → fail_code=3, done=1 on the following edge, cycle_count=10.
- data_write=1 with data_address==instr_address=32'hBFC0_0004 → fail_code=4; with the capture macro defined, fail_data_address=32'hBFC0_0004.
- TIMEOUT_CYCLES=20, cpu_active held high → fail_code=6, cycle_count=19, cpu_rst=1.
- Active drops with v0=32'h1, ref_out=32'h2 → fail_code=7, pass=0; a following start pulse clears done and counters and re-runs.
- rst driven low during RUN cycle 5 → immediately IDLE, cpu_rst=1, done=0, counters=0.
- CHECK_ALIGN=1 and a read at 32'h0000_1002 → fail_code=5.

Source files
------------

// File: rtl/mips_cpu_run_monitor.sv
// Run controller and bus-protocol checker that sits beside mips_cpu_harvard.
// Define MIPS_RUN_MONITOR_FAIL_CAPTURE_EN to add first-fail address capture ports.
module mips_cpu_run_monitor #(
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          RST_CYCLES     = 1,
   parameter int          CNT_W          = 32,
   parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI        = 32'hFFFF_FFFF,
   parameter bit          CHECK_ALIGN    = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_cpu_active,
   input  logic [31:0]      i_register_v0,
   input  logic [31:0]      i_instr_address,
   input  logic [31:0]      i_data_address,
   input  logic             i_data_read,
   input  logic             i_data_write,
   input  logic [31:0]      i_ref_out,
   output logic             o_cpu_rst,
   output logic             o_done,
   output logic             o_pass,
   output logic [2:0]       o_fail_code,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [CNT_W-1:0] o_read_count,
   output logic [CNT_W-1:0] o_write_count
`ifdef MIPS_RUN_MONITOR_FAIL_CAPTURE_EN
   ,
   output logic [31:0]      o_fail_instr_address,
   output logic [31:0]      o_fail_data_address
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_WAIT  = 3'd2,
      S_RUN   = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [15:0]      LP_RST_LAST     = 16'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [15:0]      r_rst_cnt;
   logic [2:0]       r_fail_code;
   logic [2:0]       w_new_fail;
   logic             w_rearm;
   logic             w_count_en;
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_read_count;
   logic [CNT_W-1:0] r_write_count;
   logic             r_cpu_rst;
   logic             r_done;
   logic             r_pass;
   logic             w_access;
   logic             w_below;
   logic             w_above;
   logic             w_misalign;
   logic             w_bad_addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // Window test uses the borrow of a 33-bit subtract so full-range bounds stay non-constant.
   assign w_access   = i_data_read | i_data_write;
   assign w_below    = 1'(({1'b0, i_data_address} - {1'b0, ADDR_LO}) >> 32);
   assign w_above    = 1'(({1'b0, ADDR_HI} - {1'b0, i_data_address}) >> 32);
   assign w_misalign = CHECK_ALIGN && (i_data_address[1:0] != 2'b00);
   assign w_bad_addr = w_below | w_above | w_misalign;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Lower fail codes win because they are tested first.
   always_comb begin
      w_next_state = r_state;
      w_new_fail   = 3'd0;
      w_rearm      = 1'b0;
      w_count_en   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next_state = S_RESET;
               w_rearm      = 1'b1;
            end else begin
               w_next_state = r_state;
            end
         end
         S_RESET: begin
            if ((r_rst_cnt != 16'd0) && w_access) begin
               w_new_fail   = 3'd1;
               w_next_state = S_DONE;
            end else if (r_rst_cnt == LP_RST_LAST) begin
               w_next_state = S_WAIT;
            end else begin
               w_next_state = S_RESET;
            end
         end
         S_WAIT: begin
            if (!i_cpu_active) begin
               w_new_fail   = 3'd2;
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            if (i_data_read && i_data_write) begin
               w_new_fail   = 3'd3;
               w_next_state = S_DONE;
            end else if (i_data_write && (i_data_address == i_instr_address)) begin
               w_new_fail   = 3'd4;
               w_next_state = S_DONE;
            end else if (w_access && w_bad_addr) begin
               w_new_fail   = 3'd5;
               w_next_state = S_DONE;
            end else if (!i_cpu_active) begin
               w_next_state = S_CHECK;
            end else if (r_cycle_count == LP_TIMEOUT_LAST) begin
               w_new_fail   = 3'd6;
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_RUN;
               w_count_en   = 1'b1;
            end
         end
         S_CHECK: begin
            w_next_state = S_DONE;
            if (i_register_v0 != i_ref_out) begin
               w_new_fail = 3'd7;
            end else begin
               w_new_fail = 3'd0;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rst_cnt <= 16'd0;
      end else if ((r_state == S_RESET) && (w_next_state == S_RESET)) begin
         r_rst_cnt <= r_rst_cnt + 16'd1;
      end else begin
         r_rst_cnt <= 16'd0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_fail_code <= 3'd0;
      end else if (w_rearm) begin
         r_fail_code <= 3'd0;
      end else if ((w_new_fail != 3'd0) && (r_fail_code == 3'd0)) begin
         r_fail_code <= w_new_fail;
      end else begin
         r_fail_code <= r_fail_code;
      end
   end

   // Counters only advance on RUN edges where the run carries on in RUN.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cycle_count <= {CNT_W{1'b0}};
         r_read_count  <= {CNT_W{1'b0}};
         r_write_count <= {CNT_W{1'b0}};
      end else if (w_rearm) begin
         r_cycle_count <= {CNT_W{1'b0}};
         r_read_count  <= {CNT_W{1'b0}};
         r_write_count <= {CNT_W{1'b0}};
      end else if (w_count_en) begin
         r_cycle_count <= sat_inc(r_cycle_count);
         r_read_count  <= i_data_read  ? sat_inc(r_read_count)  : r_read_count;
         r_write_count <= i_data_write ? sat_inc(r_write_count) : r_write_count;
      end else begin
         r_cycle_count <= r_cycle_count;
         r_read_count  <= r_read_count;
         r_write_count <= r_write_count;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cpu_rst <= 1'b1;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         r_cpu_rst <= (w_next_state == S_IDLE) || (w_next_state == S_RESET) ||
                      (w_next_state == S_DONE);
         r_done    <= (r_state == S_DONE) && (w_next_state == S_DONE);
         r_pass    <= (r_state == S_DONE) && (w_next_state == S_DONE) &&
                      (r_fail_code == 3'd0);
      end
   end

`ifdef MIPS_RUN_MONITOR_FAIL_CAPTURE_EN
   logic [31:0] r_fail_instr_address;
   logic [31:0] r_fail_data_address;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_fail_instr_address <= 32'h0000_0000;
         r_fail_data_address  <= 32'h0000_0000;
      end else if (w_rearm) begin
         r_fail_instr_address <= 32'h0000_0000;
         r_fail_data_address  <= 32'h0000_0000;
      end else if ((w_new_fail != 3'd0) && (r_fail_code == 3'd0)) begin
         r_fail_instr_address <= i_instr_address;
         r_fail_data_address  <= i_data_address;
      end else begin
         r_fail_instr_address <= r_fail_instr_address;
         r_fail_data_address  <= r_fail_data_address;
      end
   end

   assign o_fail_instr_address = r_fail_instr_address;
   assign o_fail_data_address  = r_fail_data_address;
`endif

   assign o_cpu_rst     = r_cpu_rst;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_fail_code   = r_fail_code;
   assign o_cycle_count = r_cycle_count;
   assign o_read_count  = r_read_count;
   assign o_write_count = r_write_count;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Randomised bench for mips_cpu_run_monitor: each run is a per-cycle CPU script
// whose outcome is predicted by walking the script against the monitor's rules.
module tb_mips_cpu_run_monitor;

   localparam int          RSTC = 3;
   localparam int          TO   = 64;
   localparam logic [31:0] LO   = 32'h0000_1000;
   localparam logic [31:0] HI   = 32'hBFFF_FFFF;
   localparam int          NS   = RSTC + 1 + TO;

   logic        clk;
   logic        rst;
   logic        start;
   logic        cpu_active;
   logic [31:0] register_v0;
   logic [31:0] instr_address;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [31:0] ref_out;
   logic        cpu_rst;
   logic        done;
   logic        pass;
   logic [2:0]  fail_code;
   logic [31:0] cycle_count;
   logic [31:0] read_count;
   logic [31:0] write_count;
`ifdef MIPS_RUN_MONITOR_FAIL_CAPTURE_EN
   logic [31:0] fail_ia;
   logic [31:0] fail_da;
`endif

   mips_cpu_run_monitor #(
      .TIMEOUT_CYCLES(TO),
      .RST_CYCLES    (RSTC),
      .CNT_W         (32),
      .ADDR_LO       (LO),
      .ADDR_HI       (HI),
      .CHECK_ALIGN   (1'b1)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start),
      .i_cpu_active   (cpu_active),
      .i_register_v0  (register_v0),
      .i_instr_address(instr_address),
      .i_data_address (data_address),
      .i_data_read    (data_read),
      .i_data_write   (data_write),
      .i_ref_out      (ref_out),
      .o_cpu_rst      (cpu_rst),
      .o_done         (done),
      .o_pass         (pass),
      .o_fail_code    (fail_code),
      .o_cycle_count  (cycle_count),
      .o_read_count   (read_count),
      .o_write_count  (write_count)
`ifdef MIPS_RUN_MONITOR_FAIL_CAPTURE_EN
      ,
      .o_fail_instr_address(fail_ia),
      .o_fail_data_address (fail_da)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // Script: index c < RSTC is a RESET cycle, c == RSTC is WAIT, then RUN cycle c-RSTC-1.
   logic        s_act [NS];
   logic        s_rd  [NS];
   logic        s_wr  [NS];
   logic [31:0] s_da  [NS];
   logic [31:0] s_ia  [NS];
   logic [31:0] s_v0;
   logic [31:0] s_ref;

   int          e_code, e_ncyc, e_lat, e_cyc, e_rd, e_wr;
   logic [31:0] e_fia, e_fda;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ri(input int j);
      return RSTC + 1 + j;
   endfunction

   task automatic clear_script();
      for (int c = 0; c < NS; c++) begin
         s_act[c] = (c >= RSTC);
         s_rd[c]  = 1'b0;
         s_wr[c]  = 1'b0;
         s_da[c]  = 32'h0000_1000;
         s_ia[c]  = (c > RSTC) ? 32'hBFC0_0000 + 32'(4 * (c - RSTC - 1)) : 32'h0000_0000;
      end
      s_v0  = 32'h0000_0007;
      s_ref = 32'h0000_0007;
   endtask

   task automatic drive_idle();
      start         = 1'b0;
      cpu_active    = 1'b0;
      data_read     = 1'b0;
      data_write    = 1'b0;
      data_address  = 32'h0000_0000;
      instr_address = 32'h0000_0000;
   endtask

   // Walk the script cycle by cycle and decide how the run ends.
   task automatic predict();
      int   c;
      logic bad;
      e_code = 0; e_rd = 0; e_wr = 0; e_cyc = 0; e_lat = 1; e_ncyc = 0;
      e_fia = 32'h0; e_fda = 32'h0;
      for (int r = 1; r < RSTC; r++) begin
         if (s_rd[r] || s_wr[r]) begin
            e_code = 1; e_ncyc = r + 1; e_fia = s_ia[r]; e_fda = s_da[r];
            return;
         end
      end
      if (!s_act[RSTC]) begin
         e_code = 2; e_ncyc = RSTC + 1; e_fia = s_ia[RSTC]; e_fda = s_da[RSTC];
         return;
      end
      for (int j = 0; j < TO; j++) begin
         c   = ri(j);
         bad = (s_rd[c] || s_wr[c]) &&
               ((s_da[c] < LO) || (s_da[c] > HI) || (s_da[c][1:0] != 2'b00));
         if (s_rd[c] && s_wr[c]) e_code = 3;
         else if (s_wr[c] && (s_da[c] == s_ia[c])) e_code = 4;
         else if (bad) e_code = 5;
         else if (!s_act[c]) begin
            e_cyc = j; e_ncyc = c + 1; e_lat = 2;
            e_code = (s_v0 != s_ref) ? 7 : 0;
            return;
         end
         else if (j == TO - 1) e_code = 6;
         if (e_code != 0) begin
            e_cyc = j; e_ncyc = c + 1; e_fia = s_ia[c]; e_fda = s_da[c];
            return;
         end
         e_rd = e_rd + int'(s_rd[c]);
         e_wr = e_wr + int'(s_wr[c]);
      end
   endtask

   task automatic run_script();
      int lat;
      predict();
      register_v0 = s_v0;
      ref_out     = s_ref;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("rearm_done", 32'(done), 32'h0);
      chk("rearm_fail_code", 32'(fail_code), 32'h0);
      chk("rearm_cycle_count", cycle_count, 32'h0);
      chk("rearm_read_count", read_count, 32'h0);
      for (int c = 0; c < e_ncyc; c++) begin
         chk("cpu_rst_phase", 32'(cpu_rst), (c < RSTC) ? 32'h1 : 32'h0);
         cpu_active    = s_act[c];
         data_read     = s_rd[c];
         data_write    = s_wr[c];
         data_address  = s_da[c];
         instr_address = s_ia[c];
         start         = (c > 0) && ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      drive_idle();
      lat = 0;
      while ((done !== 1'b1) && (lat < 8)) begin
         @(negedge clk);
         lat++;
      end
      chk("done_latency", 32'(lat), 32'(e_lat));
      chk("done", 32'(done), 32'h1);
      chk("pass", 32'(pass), (e_code == 0) ? 32'h1 : 32'h0);
      chk("fail_code", 32'(fail_code), 32'(e_code));
      chk("cycle_count", cycle_count, 32'(e_cyc));
      chk("read_count", read_count, 32'(e_rd));
      chk("write_count", write_count, 32'(e_wr));
      chk("cpu_rst_done", 32'(cpu_rst), 32'h1);
`ifdef MIPS_RUN_MONITOR_FAIL_CAPTURE_EN
      chk("fail_instr_address", fail_ia, e_fia);
      chk("fail_data_address", fail_da, e_fda);
`endif
   endtask

   task automatic gen_random();
      int kind, len, j, c, r;
      clear_script();
      kind  = int'($urandom_range(0, 7));
      len   = int'($urandom_range(1, TO + 8));
      s_v0  = $urandom;
      s_ref = ($urandom_range(0, 3) == 0) ? (s_v0 ^ 32'h0000_0100) : s_v0;
      for (int k = 0; k < TO; k++) begin
         c        = ri(k);
         r        = int'($urandom_range(0, 5));
         s_act[c] = (k < len);
         s_rd[c]  = (r == 0);
         s_wr[c]  = (r == 1);
         s_da[c]  = 32'h0000_1000 + 32'($urandom_range(0, 1023) * 4);
      end
      case (kind)
         3: begin
            c = int'($urandom_range(0, RSTC - 1));
            if ($urandom_range(0, 1) == 0) s_rd[c] = 1'b1;
            else s_wr[c] = 1'b1;
         end
         4: s_act[RSTC] = 1'b0;
         5, 6: begin
            j = int'($urandom_range(0, TO - 1));
            c = ri(j);
            case ($urandom_range(3, 5))
               3: begin
                  s_rd[c] = 1'b1; s_wr[c] = 1'b1;
                  if ($urandom_range(0, 1) == 0) s_da[c] = s_da[c] | 32'h0000_0002;
               end
               4: begin
                  s_rd[c] = 1'b0; s_wr[c] = 1'b1; s_da[c] = s_ia[c];
               end
               default: begin
                  r = int'($urandom_range(0, 2));
                  s_da[c] = (r == 0) ? 32'h0000_0800 : (r == 1) ? 32'hC000_0000 : 32'h0000_2001;
                  s_rd[c] = ($urandom_range(0, 1) == 0);
                  s_wr[c] = !s_rd[c];
               end
            endcase
         end
         default: ;
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      drive_idle();
      register_v0 = 32'h0;
      ref_out     = 32'h0;
      #12;
      chk("reset_cpu_rst", 32'(cpu_rst), 32'h1);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_pass", 32'(pass), 32'h0);
      chk("reset_fail_code", 32'(fail_code), 32'h0);
      chk("reset_cycle_count", cycle_count, 32'h0);
      chk("reset_write_count", write_count, 32'h0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      // Clean 50-cycle run with some traffic, v0 matches.
      clear_script();
      s_rd[ri(2)] = 1'b1; s_rd[ri(5)] = 1'b1; s_wr[ri(8)] = 1'b1; s_da[ri(8)] = 32'h0000_1F00;
      s_act[ri(50)] = 1'b0;
      run_script();

      // Read and write together at count 10.
      clear_script();
      s_rd[ri(10)] = 1'b1; s_wr[ri(10)] = 1'b1;
      run_script();

      // Write onto the instruction address.
      clear_script();
      s_wr[ri(1)] = 1'b1; s_da[ri(1)] = 32'hBFC0_0004;
      run_script();

      // Active never drops: timeout.
      clear_script();
      run_script();

      // v0 mismatch, then a re-arm in the next run clears everything.
      clear_script();
      s_v0 = 32'h0000_0001; s_ref = 32'h0000_0002; s_act[ri(20)] = 1'b0;
      run_script();

      // Misaligned read.
      clear_script();
      s_rd[ri(3)] = 1'b1; s_da[ri(3)] = 32'h0000_1002;
      run_script();

      // Async reset in the middle of a run.
      clear_script();
      s_rd[ri(1)] = 1'b1; s_rd[ri(3)] = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < ri(5); c++) begin
         cpu_active = s_act[c]; data_read = s_rd[c]; data_write = s_wr[c];
         data_address = s_da[c]; instr_address = s_ia[c];
         @(negedge clk);
      end
      chk("midrun_cycle_count", cycle_count, 32'd5);
      #2 rst = 1'b0;
      #1;
      chk("midrun_cpu_rst", 32'(cpu_rst), 32'h1);
      chk("midrun_done", 32'(done), 32'h0);
      chk("midrun_cycle_clr", cycle_count, 32'h0);
      chk("midrun_read_clr", read_count, 32'h0);
      drive_idle();
      @(negedge clk); rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_done", 32'(done), 32'h0);
         chk("idle_cpu_rst", 32'(cpu_rst), 32'h1);
      end

      for (int n = 0; n < 30; n++) begin
         gen_random();
         run_script();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
